// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, opcodes
// of interest and the branch offset helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [5:0] OPC_BEQ    = 6'b000100;
  localparam logic [5:0] OPC_J      = 6'b000010;
  localparam int         WORD_BYTES = 4;

  // Sign-extended 16-bit immediate scaled to a byte offset (low bits always 00).
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    return $signed({{14{imm[15]}}, imm, 2'b00});
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC selection: jump beats taken branch beats fall-through.
module next_pc_select
  import fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] Instruction,
  input  logic        Its_a_branch,
  input  logic        Its_a_jump,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic signed [31:0] br_offset;
  logic        [31:0] br_target;
  logic        [31:0] jmp_target;

  assign br_offset  = branch_offset(Instruction[15:0]);
  assign br_target  = pc_plus4 + $unsigned(br_offset);
  assign jmp_target = {pc_plus4[31:28], Instruction[25:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (Its_a_jump) begin
      next_pc = jmp_target;
    end else if (Its_a_branch && alu_zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, req/ack instruction memory handshake with timeout,
// instruction register and next-PC update driven by the control unit.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        Its_a_branch,
  input  logic        Its_a_jump,
  input  logic        alu_zero,
  input  logic        hold,
  output logic [31:0] Instruction,
  output logic [5:0]  Op_code,
  output logic [5:0]  Func_code,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  localparam logic [31:0] PC_INIT   = RESET_PC & ~32'h3;
  localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state;
  logic [7:0]   wait_cnt;
  logic [31:0]  next_pc;

  assign imem_addr = pc;
  assign Op_code   = Instruction[31:26];
  assign Func_code = Instruction[5:0];
  assign pc_plus4  = pc + 32'(WORD_BYTES);

  next_pc_select u_next_pc_select (
    .pc_plus4     (pc_plus4),
    .Instruction  (Instruction),
    .Its_a_branch (Its_a_branch),
    .Its_a_jump   (Its_a_jump),
    .alu_zero     (alu_zero),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= PC_INIT;
      Instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        // Ack is checked before the timeout so a last-moment response still issues.
        ST_FETCH: begin
          if (imem_ack) begin
            Instruction <= imem_rdata;
            wait_cnt    <= '0;
            state       <= ST_ISSUE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ST_FAULT;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ISSUE: begin
          if (!hold) begin
            pc          <= next_pc;
            state       <= ST_FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
